// File: rtl/fp_pkg.sv
// Shared floating-point types and constants for the adder datapath.
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;
    localparam int unsigned GRS_W     = 3;

    // Bit positions inside the two-bit special-operand flag.
    localparam int unsigned SPC_INF = 0;
    localparam int unsigned SPC_NAN = 1;

    // Packed operand at the default width: {sign, exp, frac}.
    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF-1:0] frac;
    } fp_t;

    // Unpacked view: hidden bit restored, subnormal exponent forced to 1.
    typedef struct packed {
        logic                 sign;
        logic                 hidden;
        logic [EXP_W_DEF-1:0] eff_exp;
        logic [MAN_W_DEF-1:0] frac;
    } fp_unp_t;

endpackage

// File: rtl/fp_sticky_shift.sv
// Right shift with sticky OR of the shifted-out bits; saturates for large shifts.
module fp_sticky_shift
    import fp_pkg::*;
#(
    parameter int unsigned SIG_W = MAN_W_DEF + 1 + GRS_W,
    parameter int unsigned SH_W  = 5
) (
    input  logic [SIG_W-1:0] x,
    input  logic [SH_W-1:0]  sh,
    output logic [SIG_W-1:0] y_c
);

    logic [SIG_W-1:0] mask_c;
    logic             sticky_c;

    // Shift, then fold everything that fell off the bottom into bit 0.
    always_comb begin
        mask_c   = '0;
        sticky_c = 1'b0;
        y_c      = '0;
        if (32'(sh) >= SIG_W) begin
            y_c = {{(SIG_W-1){1'b0}}, |x};
        end else begin
            mask_c   = ~({SIG_W{1'b1}} << sh);
            sticky_c = |(x & mask_c);
            y_c      = (x >> sh) | {{(SIG_W-1){1'b0}}, sticky_c};
        end
    end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage valid/ready exponent alignment for the floating-point adder.
module fp_align_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [EXP_W+MAN_W:0]     a_in,
    input  logic [EXP_W+MAN_W:0]     b_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic                     sign_big,
    output logic                     sign_small,
    output logic [EXP_W-1:0]         exp_out,
    output logic [MAN_W+GRS_W:0]     sig_big,
    output logic [MAN_W+GRS_W:0]     sig_small,
    output logic                     swapped,
    output logic [1:0]               special
);

    localparam int unsigned SIG_W = MAN_W + 1 + GRS_W;
    localparam int unsigned SH_W  = $clog2(SIG_W + 1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } op_t;

    op_t              a_op_c, b_op_c;
    logic             a_hid_c, b_hid_c;
    logic [EXP_W-1:0] a_eff_c, b_eff_c, d_c;
    logic             swap_c;
    logic             sign_big_c, sign_small_c;
    logic [EXP_W-1:0] exp_big_c;
    logic [SIG_W-1:0] sig_big_c, sig_small_c;
    logic [SH_W-1:0]  sh_c;
    logic [1:0]       special_c;
    logic             s2_adv_c, s1_adv_c;
    logic [SIG_W-1:0] shifted_c;

    logic             s1_valid;
    logic             s1_sign_big, s1_sign_small, s1_swapped;
    logic [EXP_W-1:0] s1_exp;
    logic [SIG_W-1:0] s1_sig_big, s1_sig_small;
    logic [SH_W-1:0]  s1_sh;
    logic [1:0]       s1_special;

    // Unpack both operands, order them by effective exponent, saturate the distance.
    always_comb begin
        a_op_c       = a_in;
        b_op_c       = b_in;
        a_hid_c      = |a_op_c.exp;
        b_hid_c      = |b_op_c.exp;
        a_eff_c      = a_hid_c ? a_op_c.exp : EXP_W'(1);
        b_eff_c      = b_hid_c ? b_op_c.exp : EXP_W'(1);
        swap_c       = (b_eff_c > a_eff_c);
        sign_big_c   = swap_c ? b_op_c.sign : a_op_c.sign;
        sign_small_c = swap_c ? a_op_c.sign : b_op_c.sign;
        exp_big_c    = swap_c ? b_eff_c : a_eff_c;
        d_c          = swap_c ? (b_eff_c - a_eff_c) : (a_eff_c - b_eff_c);
        sig_big_c    = swap_c ? {b_hid_c, b_op_c.frac, {GRS_W{1'b0}}}
                              : {a_hid_c, a_op_c.frac, {GRS_W{1'b0}}};
        sig_small_c  = swap_c ? {a_hid_c, a_op_c.frac, {GRS_W{1'b0}}}
                              : {b_hid_c, b_op_c.frac, {GRS_W{1'b0}}};
        sh_c         = (32'(d_c) >= SIG_W) ? SH_W'(SIG_W) : SH_W'(d_c);
        special_c    = 2'b00;
        special_c[SPC_INF] = (&a_op_c.exp && !(|a_op_c.frac)) ||
                             (&b_op_c.exp && !(|b_op_c.frac));
        special_c[SPC_NAN] = (&a_op_c.exp && (|a_op_c.frac)) ||
                             (&b_op_c.exp && (|b_op_c.frac));
    end

    // A stage moves when the stage after it is empty or draining.
    assign s2_adv_c = !valid_out || ready_out;
    assign s1_adv_c = !s1_valid || s2_adv_c;
    assign ready_in = s1_adv_c;

    // Stage 1: capture the ordered, unpacked operand pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_sign_big   <= 1'b0;
            s1_sign_small <= 1'b0;
            s1_swapped    <= 1'b0;
            s1_exp        <= '0;
            s1_sig_big    <= '0;
            s1_sig_small  <= '0;
            s1_sh         <= '0;
            s1_special    <= 2'b00;
        end else if (s1_adv_c) begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_sign_big   <= sign_big_c;
                s1_sign_small <= sign_small_c;
                s1_swapped    <= swap_c;
                s1_exp        <= exp_big_c;
                s1_sig_big    <= sig_big_c;
                s1_sig_small  <= sig_small_c;
                s1_sh         <= sh_c;
                s1_special    <= special_c;
            end
        end
    end

    fp_sticky_shift #(
        .SIG_W (SIG_W),
        .SH_W  (SH_W)
    ) u_shift (
        .x   (s1_sig_small),
        .sh  (s1_sh),
        .y_c (shifted_c)
    );

    // Stage 2: capture the aligned small significand; doubles as the output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_out  <= 1'b0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            exp_out    <= '0;
            sig_big    <= '0;
            sig_small  <= '0;
            swapped    <= 1'b0;
            special    <= 2'b00;
        end else if (s2_adv_c) begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                sign_big   <= s1_sign_big;
                sign_small <= s1_sign_small;
                exp_out    <= s1_exp;
                sig_big    <= s1_sig_big;
                sig_small  <= shifted_c;
                swapped    <= s1_swapped;
                special    <= s1_special;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe: arithmetic reference model plus literal vectors.
module tb_fp_align_pipe;
    import fp_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] a_in, b_in;
    logic        valid_in, ready_in, valid_out, ready_out;
    logic        sign_big, sign_small, swapped;
    logic [7:0]  exp_out;
    logic [26:0] sig_big, sig_small;
    logic [1:0]  special;

    int n_tests = 0;
    int n_fail  = 0;
    int n_drained = 0;

    typedef struct {
        logic        sb;
        logic        ss;
        logic [7:0]  e;
        logic [26:0] gb;
        logic [26:0] gs;
        logic        sw;
        logic [1:0]  spc;
    } res_t;

    res_t q[$];

    fp_align_pipe dut (
        .clock      (clock),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .exp_out    (exp_out),
        .sig_big    (sig_big),
        .sig_small  (sig_small),
        .swapped    (swapped),
        .special    (special)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Reference: integer arithmetic on significands, shift as division by 2^d.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        fp_t         fa, fb;
        logic [63:0] ea, eb, ma, mb, big_e, small_e, mbig, msmall, d, xs, den, qv;
        logic        sw, inf, nan;
        fa = a;
        fb = b;
        ea = (fa.exp == 8'd0) ? 64'd1 : 64'(fa.exp);
        eb = (fb.exp == 8'd0) ? 64'd1 : 64'(fb.exp);
        ma = ((fa.exp != 8'd0) ? 64'd8388608 : 64'd0) + 64'(fa.frac);
        mb = ((fb.exp != 8'd0) ? 64'd8388608 : 64'd0) + 64'(fb.frac);
        sw = (eb > ea);
        big_e   = sw ? eb : ea;
        small_e = sw ? ea : eb;
        mbig    = sw ? mb : ma;
        msmall  = sw ? ma : mb;
        d  = big_e - small_e;
        xs = msmall * 64'd8;
        if (d >= 64'd27) begin
            qv = (xs != 64'd0) ? 64'd1 : 64'd0;
        end else begin
            den = 64'd1 << d;
            qv  = xs / den;
            if ((xs % den) != 64'd0) qv = qv | 64'd1;
        end
        inf = (fa.exp == 8'hFF && fa.frac == 23'd0) || (fb.exp == 8'hFF && fb.frac == 23'd0);
        nan = (fa.exp == 8'hFF && fa.frac != 23'd0) || (fb.exp == 8'hFF && fb.frac != 23'd0);
        r.sb  = sw ? fb.sign : fa.sign;
        r.ss  = sw ? fa.sign : fb.sign;
        r.e   = 8'(big_e);
        r.gb  = 27'(mbig * 64'd8);
        r.gs  = 27'(qv);
        r.sw  = sw;
        r.spc = {nan, inf};
        return r;
    endfunction

    // Per-cycle compare: handshake against occupancy, outputs against queued model results.
    always @(negedge clock) begin
        if (reset) begin
            q.delete();
        end else begin
            chk("m_ready_in", 32'(ready_in), 32'(!(q.size() == 2 && !ready_out)));
            if (valid_out) begin
                if (q.size() == 0) begin
                    chk("m_spurious_valid", 32'(valid_out), 32'd0);
                end else begin
                    chk("m_sign_big",   32'(sign_big),   32'(q[0].sb));
                    chk("m_sign_small", 32'(sign_small), 32'(q[0].ss));
                    chk("m_exp_out",    32'(exp_out),    32'(q[0].e));
                    chk("m_sig_big",    32'(sig_big),    32'(q[0].gb));
                    chk("m_sig_small",  32'(sig_small),  32'(q[0].gs));
                    chk("m_swapped",    32'(swapped),    32'(q[0].sw));
                    chk("m_special",    32'(special),    32'(q[0].spc));
                    if (ready_out) begin
                        void'(q.pop_front());
                        n_drained++;
                    end
                end
            end
            if (valid_in && ready_in) q.push_back(model(a_in, b_in));
        end
    end

    // Present one pair and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        a_in = a;
        b_in = b;
        valid_in = 1'b1;
        n = 0;
        @(negedge clock);
        while (!ready_in && n < 20) begin
            n++;
            @(negedge clock);
        end
        if (!ready_in) chk("send_timeout", 32'(ready_in), 32'd1);
        @(posedge clock);
        #1;
        valid_in = 1'b0;
    endtask

    // One pair through an empty pipe with ready_out=1, checked against literals.
    task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] e, input logic [26:0] gb, input logic [26:0] gs,
                           input logic sw, input logic [1:0] spc);
        send(a, b);
        @(negedge clock);
        chk({name, "_lat1"}, 32'(valid_out), 32'd0);
        @(negedge clock);
        chk({name, "_lat2"}, 32'(valid_out), 32'd1);
        chk({name, "_exp"},  32'(exp_out),   32'(e));
        chk({name, "_sigb"}, 32'(sig_big),   32'(gb));
        chk({name, "_sigs"}, 32'(sig_small), 32'(gs));
        chk({name, "_swap"}, 32'(swapped),   32'(sw));
        chk({name, "_spc"},  32'(special),   32'(spc));
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, 32'(valid_out), 32'd0);
        chk({name, "_ready"}, 32'(ready_in),  32'd1);
        chk({name, "_data"},  32'({sign_big, sign_small, exp_out}), 32'd0);
        chk({name, "_sigb"},  32'(sig_big),   32'd0);
        chk({name, "_sigs"},  32'(sig_small), 32'd0);
        chk({name, "_flags"}, 32'({swapped, special}), 32'd0);
    endtask

    initial begin
        int n0;
        int n;
        reset = 1'b1;
        valid_in = 1'b0;
        ready_out = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        ready_out = 1'b1;

        run_lit("basic",  32'h40000000, 32'h3F800000, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 2'b00);
        run_lit("swap",   32'h3F800000, 32'h41200000, 8'h82, 27'h5000000, 27'h0800000, 1'b1, 2'b00);
        run_lit("d23",    32'h4B000000, 32'h3F800001, 8'h96, 27'h4000000, 27'h0000009, 1'b0, 2'b00);
        run_lit("dbig",   32'h7F000000, 32'h3F800000, 8'hFE, 27'h4000000, 27'h0000001, 1'b0, 2'b00);
        run_lit("subn",   32'h00800000, 32'h00000001, 8'h01, 27'h4000000, 27'h0000008, 1'b0, 2'b00);
        run_lit("eqexp",  32'h3F800000, 32'h3FC00000, 8'h7F, 27'h4000000, 27'h6000000, 1'b0, 2'b00);
        run_lit("d25",    32'h4C000000, 32'h3F800000, 8'h98, 27'h4000000, 27'h0000002, 1'b0, 2'b00);
        run_lit("zero27", 32'h0E000000, 32'h00000000, 8'h1C, 27'h4000000, 27'h0000000, 1'b0, 2'b00);
        run_lit("inf",    32'h7F800000, 32'h3F800000, 8'hFF, 27'h4000000, 27'h0000001, 1'b0, 2'b01);
        run_lit("nan",    32'h3F800000, 32'h7FC00000, 8'hFF, 27'h6000000, 27'h0000001, 1'b1, 2'b10);

        // Backpressure: four pairs back to back while the consumer stalls for four cycles.
        n0 = n_drained;
        ready_out = 1'b0;
        fork
            begin
                send(32'h7F800000, 32'h3F800000);
                send(32'h3F800000, 32'h7FC00000);
                send(32'h40000000, 32'h3F800000);
                send(32'hBF800000, 32'h41200000);
            end
            begin
                repeat (4) @(posedge clock);
                #1;
                ready_out = 1'b1;
            end
        join
        n = 0;
        while ((q.size() != 0 || valid_out) && n < 20) begin
            n++;
            @(negedge clock);
        end
        chk("bp_drained", 32'(q.size()), 32'd0);
        chk("bp_count", 32'(n_drained - n0), 32'd4);
        @(posedge clock);
        #1;

        // Reset with both stages full and the consumer stalled.
        ready_out = 1'b0;
        send(32'h40000000, 32'h3F800000);
        send(32'h3F800000, 32'h41200000);
        @(negedge clock);
        chk("full_valid", 32'(valid_out), 32'd1);
        chk("full_ready", 32'(ready_in),  32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        ready_out = 1'b1;
        @(negedge clock);
        chk_zero("midrst");
        @(posedge clock);
        #1;
        run_lit("postrst", 32'h4B000000, 32'h3F800001, 8'h96, 27'h4000000, 27'h0000009, 1'b0, 2'b00);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_align_pipe.md
# fp_align_pipe

Pipelined, parametrised alignment stage for the floating-point adder datapath. It accepts two packed IEEE-754-style operands and unpacks them. It orders them by exponent and right-shifts the smaller operand's significand by the exponent difference, producing guard/round/sticky bits for the rounding stage. It sits between the operand input and the add/normalise stage, replacing the single-precision combinational mask-plus-align pair with a valid/ready, two-stage, width-generic block that handles subnormals and specials.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa (fraction) width; significand is MAN_W+1 bits
- SIG_W, MAN_W+4, derived output significand width: hidden bit, fraction, G, R, S (not overridable)
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- a_in, b_in  in  1+EXP_W+MAN_W each  packed operands {sign, exp, frac}
- valid_in  in  1  operand pair present
- ready_in  out  1  block can accept this cycle
- valid_out  out  1  aligned result present
- ready_out  in  1  downstream accepts this cycle
- sign_big, sign_small  out  1 each  signs of larger-exponent / smaller-exponent operand
- exp_out  out  EXP_W  effective exponent of larger operand (normalisation exponent)
- sig_big  out  SIG_W  {hidden, frac, 3'b000} of larger operand
- sig_small  out  SIG_W  smaller operand's significand, shifted, with G/R/S in low 3 bits
- swapped  out  1  1 when B was selected as larger operand
- special  out  2  bit0: either exponent all-ones with zero fraction (Inf); bit1: either exponent all-ones with nonzero fraction (NaN)

## Operation
- Unpack: hidden bit = (exp != 0). Effective exponent = exp, or 1 when exp == 0 (subnormal/zero).
- Ordering: swap (B large) only if eff_exp_B > eff_exp_A. On equal exponents, A is large and swapped=0. No mantissa compare.
- d = eff_exp_big - eff_exp_small, unsigned EXP_W bits, never negative after ordering.
- Shift: form X = {hidden_small, frac_small, 3'b000} (SIG_W bits).
  - If d < SIG_W: sig_small = (X >> d) with bit0 ORed with OR of all bits shifted out.
  - If d >= SIG_W: sig_small = {(SIG_W-1)'b0, |X}.
- exp_out = eff_exp_big. Specials are flagged only; data is still aligned normally, and downstream resolves them.
- Stage 1 registers unpack, compare, swap, and saturated d. Stage 2 registers shift and sticky.

## Timing
- Latency: 2 cycles from accepted input (valid_in && ready_in) to valid_out, with no stall.
- Throughput: one pair per cycle while ready_out=1.
- Handshake:
  - Stage k advances when its successor is empty or being drained.
  - ready_in = !s1_valid || s2 advancing.
  - valid_out is held, and every output is stable, while valid_out && !ready_out.
  - valid_out does not depend combinationally on valid_in.
- Full: both stages valid and ready_out=0 -> ready_in=0; input ignored.
- Simultaneous drain and accept when full: accepted without bubble.
- Reset, including mid-operation: next edge clears s1_valid and s2_valid. valid_out=0, ready_in=1, and all data outputs are 0 (special=2'b00, swapped=0). In-flight data is discarded.

## Structure
- Shared package fp_pkg:
  - EXP_W/MAN_W defaults
  - packed struct fp_t {sign, exp, frac}
  - unpacked struct with hidden bit and effective exponent
  - GRS width constant (3)
  - special-flag bit indices
- One sub-module: fp_sticky_shift (combinational, parametrised right shift with sticky OR and saturation), instantiated in stage 2.
- Pipeline registers and handshake stay in fp_align_pipe.

## Test plan
- A=0x40000000, B=0x3F800000, ready_out=1 -> 2 cycles later: exp_out=0x80, sig_big=0x4000000, sig_small=0x2000000, swapped=0, special=0.
- A=0x3F800000, B=0x41200000 -> exp_out=0x82, sig_big=0x5000000, sig_small=0x0800000, swapped=1.
- Sticky checks:
  - A=0x4B000000, B=0x3F800001 (d=23) -> sig_small=0x0000009.
  - A=0x7F000000, B=0x3F800000 (d>=27) -> sig_small=0x0000001.
- Subnormal: A=0x00800000, B=0x00000001 -> exp_out=0x01, d=0, sig_big=0x4000000, sig_small=0x0000008.
- Backpressure: 4 back-to-back pairs with ready_out=0 for 4 cycles -> ready_in drops after 2 accepts, outputs held stable, all 4 results emerge in order with none lost or duplicated. Also check A=0x7F800000 -> special=2'b01 and B=0x7FC00000 -> special=2'b10.
- Reset asserted with both stages full and ready_out=0 -> next cycle valid_out=0, ready_in=1, outputs 0. The first post-reset input appears 2 cycles after acceptance.
